// File: rtl/lcd_pixel_fifo.sv
// ============================================================================
// lcd_pixel_fifo
// ----------------------------------------------------------------------------
// Purpose:
//   Single-clock pixel elastic buffer placed directly in front of the RGB LCD
//   driver. An RGB565 stream with start-of-frame marking arrives from a
//   valid/ready source. The buffer answers each driver data_req with a pixel
//   on the following lcd_clk. On every rising edge of out_vsync the buffer
//   is flushed, and it then waits for the next source start-of-frame word so
//   that the driver frame and the source frame line up again. A request that
//   finds the buffer empty is answered with UNDERFLOW_COLOR.
//
// Optional feature macro:
//   LCD_FIFO_STATS_EN - adds the underflow_cnt port, a saturating 16-bit count
//                       of starved requests. Only reset clears it.
//
// Parameters:
//   DEPTH_LOG2      - the buffer holds 2**DEPTH_LOG2 words of 16 bits
//   UNDERFLOW_COLOR - pixel returned when no data is available
//
// Ports:
//   lcd_clk       in   pixel clock, rising edge
//   sys_rst_n     in   asynchronous active-low reset
//   in_data       in   RGB565 pixel from the source
//   in_sof        in   marks in_data as pixel (0,0) of a frame
//   in_valid      in   source word valid
//   in_ready      out  source word accepted when in_valid && in_ready (combinational)
//   out_vsync     in   frame restart from the driver, acts on its rising edge
//   data_req      in   driver requests one pixel
//   pixel_data    out  registered pixel answering data_req
//   fill_level    out  registered count of words held
//   underflow     out  sticky flag, a starved request occurred in this frame
//   frame_active  out  high while the buffer is in RUN
//   underflow_cnt out  starved-request counter (LCD_FIFO_STATS_EN only)
// ============================================================================
module lcd_pixel_fifo #(
    parameter int          DEPTH_LOG2      = 10,
    parameter logic [15:0] UNDERFLOW_COLOR = 16'h0000
) (
    input  logic                  lcd_clk,
    input  logic                  sys_rst_n,
    input  logic [15:0]           in_data,
    input  logic                  in_sof,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  out_vsync,
    input  logic                  data_req,
    output logic [15:0]           pixel_data,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  underflow,
    output logic                  frame_active
`ifdef LCD_FIFO_STATS_EN
    ,
    output logic [15:0]           underflow_cnt
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_SYNC,
        ST_RUN
    } state_t;

    state_t                r_state;
    state_t                w_nextState;

    logic                  r_vsD;
    logic                  w_vsRise;

    logic [15:0]           r_mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2:0]   r_fillLevel;
    logic [15:0]           w_headData;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_inReady;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_starved;

    logic [15:0]           r_pixelData;
    logic                  r_underflow;
    logic                  r_frameActive;

    assign w_vsRise   = out_vsync & ~r_vsD;
    assign w_full     = (r_fillLevel == FULL_LEVEL);
    assign w_empty    = (r_fillLevel == '0);
    assign w_headData = r_mem[r_rdPtr];

    // Delayed copy of out_vsync. A driver that holds vsync high for many
    // cycles must still trigger only one flush, so only the 0->1 edge counts.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_vsD <= 1'b0;
        end else begin
            r_vsD <= out_vsync;
        end
    end

    // State register for the frame-alignment controller.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and source handshake. A vsync edge wins over everything else
    // and blocks the source for that cycle, because any word taken then would
    // be thrown away by the flush that follows. SYNC takes words freely so
    // that the source can run ahead to its next start-of-frame word.
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        if (w_vsRise) begin
            w_nextState = ST_FLUSH;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nextState = ST_IDLE;
                end
                ST_FLUSH: begin
                    w_nextState = ST_SYNC;
                end
                ST_SYNC: begin
                    w_inReady = 1'b1;
                    if (in_valid && in_sof) begin
                        w_nextState = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_inReady = ~w_full;
                end
                default: begin
                    w_nextState = ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = w_inReady;

    // In SYNC only the start-of-frame word is stored. The others are accepted
    // and dropped. In RUN every accepted word is stored, including a stray
    // start-of-frame word.
    assign w_accept  = in_valid & w_inReady;
    assign w_push    = w_accept & ((r_state == ST_RUN) | ((r_state == ST_SYNC) & in_sof));
    assign w_pop     = data_req & (r_state == ST_RUN) & ~w_empty;
    assign w_starved = data_req & (r_state == ST_RUN) & w_empty;

    // Pixel storage. This block has no reset, so it can map onto block RAM.
    // Pointer and level logic decides which entries are valid.
    always_ff @(posedge lcd_clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= in_data;
        end
    end

    // Pointers and occupancy. The pointers wrap at the depth. Full and empty
    // come from the level counter, which has one extra bit so that a full
    // buffer and an empty buffer are never confused.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_fillLevel <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_fillLevel <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_fillLevel <= r_fillLevel + LEVEL_ONE;
                2'b01:   r_fillLevel <= r_fillLevel - LEVEL_ONE;
                default: r_fillLevel <= r_fillLevel;
            endcase
        end
    end

    // Pixel returned to the driver one cycle after its request. A request
    // that cannot be served, either because the buffer is empty or because
    // no frame is running, returns the fill colour. With no request the
    // pixel holds its last value.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_pixelData <= 16'h0000;
        end else if (data_req) begin
            if (w_pop) begin
                r_pixelData <= w_headData;
            end else begin
                r_pixelData <= UNDERFLOW_COLOR;
            end
        end
    end

    // Sticky per-frame underflow flag. It is cleared together with the
    // buffer contents, so it describes only the current frame.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_underflow <= 1'b0;
        end else if (r_state == ST_FLUSH) begin
            r_underflow <= 1'b0;
        end else if (w_starved) begin
            r_underflow <= 1'b1;
        end
    end

    // frame_active is registered from the next state. It therefore rises in
    // the first RUN cycle and matches the state exactly.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_frameActive <= 1'b0;
        end else begin
            r_frameActive <= (w_nextState == ST_RUN);
        end
    end

    assign pixel_data   = r_pixelData;
    assign fill_level   = r_fillLevel;
    assign underflow    = r_underflow;
    assign frame_active = r_frameActive;

`ifdef LCD_FIFO_STATS_EN
    logic [15:0] r_underflowCnt;

    // Lifetime starved-request count. It survives frame flushes so that
    // software can read totals across many frames. It saturates and does
    // not wrap.
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_underflowCnt <= 16'h0000;
        end else if (w_starved && (r_underflowCnt != 16'hFFFF)) begin
            r_underflowCnt <= r_underflowCnt + 16'h0001;
        end
    end

    assign underflow_cnt = r_underflowCnt;
`endif

endmodule

// File: tb/tb_lcd_pixel_fifo.sv
// ============================================================================
// tb_lcd_pixel_fifo
// ----------------------------------------------------------------------------
// Directed testbench for lcd_pixel_fifo. The buffer is built with
// DEPTH_LOG2=4 so that the full condition is quick to reach. The fill colour
// is set to a value that differs from the reset pixel. The scenario tasks run
// in sequence, and each task starts from the state left by the task before.
// ============================================================================
module tb_lcd_pixel_fifo;

    localparam int          DEPTH_LOG2 = 4;
    localparam logic [15:0] FILL_COLOR = 16'hF800;

    logic                lcd_clk;
    logic                sys_rst_n;
    logic [15:0]         in_data;
    logic                in_sof;
    logic                in_valid;
    logic                in_ready;
    logic                out_vsync;
    logic                data_req;
    logic [15:0]         pixel_data;
    logic [DEPTH_LOG2:0] fill_level;
    logic                underflow;
    logic                frame_active;
`ifdef LCD_FIFO_STATS_EN
    logic [15:0]         underflow_cnt;
`endif

    int testsRun;
    int testsFailed;

    lcd_pixel_fifo #(
        .DEPTH_LOG2      (DEPTH_LOG2),
        .UNDERFLOW_COLOR (FILL_COLOR)
    ) dut (
        .lcd_clk      (lcd_clk),
        .sys_rst_n    (sys_rst_n),
        .in_data      (in_data),
        .in_sof       (in_sof),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_vsync    (out_vsync),
        .data_req     (data_req),
        .pixel_data   (pixel_data),
        .fill_level   (fill_level),
        .underflow    (underflow),
        .frame_active (frame_active)
`ifdef LCD_FIFO_STATS_EN
        ,
        .underflow_cnt(underflow_cnt)
`endif
    );

    initial lcd_clk = 1'b0;
    always #5 lcd_clk = ~lcd_clk;

    // Advance n rising edges. Control returns 1 ns after the last edge, when
    // registered outputs are stable and new inputs can be driven.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge lcd_clk);
            #1;
        end
    endtask

    // Present one source word for a single cycle.
    task automatic applyStimulus(input logic [15:0] data, input logic sof);
        in_data  = data;
        in_sof   = sof;
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        step(2);
        if (pixel_data !== 16'h0000) begin $display("[TB] FAIL reset_pixel: got %h, expected 0000", pixel_data); testsFailed++; end
        testsRun++;
        if (fill_level !== 5'd0) begin $display("[TB] FAIL reset_fill: got %0d, expected 0", fill_level); testsFailed++; end
        testsRun++;
        if (underflow !== 1'b0) begin $display("[TB] FAIL reset_underflow: got %b, expected 0", underflow); testsFailed++; end
        testsRun++;
        if (frame_active !== 1'b0) begin $display("[TB] FAIL reset_frame_active: got %b, expected 0", frame_active); testsFailed++; end
        testsRun++;
        if (in_ready !== 1'b0) begin $display("[TB] FAIL reset_in_ready: got %b, expected 0", in_ready); testsFailed++; end
        testsRun++;
`ifdef LCD_FIFO_STATS_EN
        if (underflow_cnt !== 16'd0) begin $display("[TB] FAIL reset_cnt: got %0d, expected 0", underflow_cnt); testsFailed++; end
        testsRun++;
`endif
        sys_rst_n = 1'b1;
        step(1);
    endtask

    // Long vsync pulse, then a stray word, the start-of-frame word and one
    // more word. The stray word must be dropped.
    task automatic test_sync_and_read();
        out_vsync = 1'b1;
        step(101);
        out_vsync = 1'b0;
        in_data  = 16'h0001;
        in_valid = 1'b1;
        #1;
        if (in_ready !== 1'b1) begin $display("[TB] FAIL sync_in_ready: got %b, expected 1", in_ready); testsFailed++; end
        testsRun++;
        applyStimulus(16'h0001, 1'b0);
        applyStimulus(16'h1234, 1'b1);
        applyStimulus(16'h5678, 1'b0);
        if (frame_active !== 1'b1) begin $display("[TB] FAIL run_frame_active: got %b, expected 1", frame_active); testsFailed++; end
        testsRun++;
        if (fill_level !== 5'd2) begin $display("[TB] FAIL sync_drop_fill: got %0d, expected 2", fill_level); testsFailed++; end
        testsRun++;
        data_req = 1'b1;
        step(1);
        if (pixel_data !== 16'h1234) begin $display("[TB] FAIL read_first: got %h, expected 1234", pixel_data); testsFailed++; end
        testsRun++;
        step(1);
        data_req = 1'b0;
        if (pixel_data !== 16'h5678) begin $display("[TB] FAIL read_second: got %h, expected 5678", pixel_data); testsFailed++; end
        testsRun++;
        step(1);
        if (pixel_data !== 16'h5678) begin $display("[TB] FAIL read_hold: got %h, expected 5678", pixel_data); testsFailed++; end
        testsRun++;
    endtask

    // Fill all 16 entries, check back-pressure, then drain through the
    // pointer wrap and check the order.
    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            in_data  = 16'hA000 + 16'(i);
            in_valid = 1'b1;
            step(1);
        end
        in_data = 16'hDEAD;
        #1;
        if (fill_level !== 5'd16) begin $display("[TB] FAIL full_fill: got %0d, expected 16", fill_level); testsFailed++; end
        testsRun++;
        if (in_ready !== 1'b0) begin $display("[TB] FAIL full_in_ready: got %b, expected 0", in_ready); testsFailed++; end
        testsRun++;
        data_req = 1'b1;
        step(1);
        data_req = 1'b0;
        if (fill_level !== 5'd15) begin $display("[TB] FAIL full_pop_fill: got %0d, expected 15", fill_level); testsFailed++; end
        testsRun++;
        if (in_ready !== 1'b1) begin $display("[TB] FAIL full_pop_in_ready: got %b, expected 1", in_ready); testsFailed++; end
        testsRun++;
        if (pixel_data !== 16'hA000) begin $display("[TB] FAIL full_pop_data: got %h, expected a000", pixel_data); testsFailed++; end
        testsRun++;
        in_valid = 1'b0;
        data_req = 1'b1;
        for (int i = 1; i < 16; i++) begin
            step(1);
            if (pixel_data !== (16'hA000 + 16'(i))) begin
                $display("[TB] FAIL full_drain_%0d: got %h, expected %h", i, pixel_data, 16'hA000 + 16'(i));
                testsFailed++;
            end
            testsRun++;
        end
        data_req = 1'b0;
        if (fill_level !== 5'd0) begin $display("[TB] FAIL full_drained_fill: got %0d, expected 0", fill_level); testsFailed++; end
        testsRun++;
    endtask

    // Push and pop together at level 3. The level must stay at 3 and the
    // pixels must come out in the order they went in.
    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'hC000 + 16'(i), 1'b0);
        end
        for (int k = 0; k < 10; k++) begin
            in_data  = 16'hC003 + 16'(k);
            in_valid = 1'b1;
            data_req = 1'b1;
            step(1);
            if (fill_level !== 5'd3) begin $display("[TB] FAIL b2b_fill_%0d: got %0d, expected 3", k, fill_level); testsFailed++; end
            testsRun++;
            if (pixel_data !== (16'hC000 + 16'(k))) begin
                $display("[TB] FAIL b2b_data_%0d: got %h, expected %h", k, pixel_data, 16'hC000 + 16'(k));
                testsFailed++;
            end
            testsRun++;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            if (pixel_data !== (16'hC00A + 16'(k))) begin
                $display("[TB] FAIL b2b_tail_%0d: got %h, expected %h", k, pixel_data, 16'hC00A + 16'(k));
                testsFailed++;
            end
            testsRun++;
        end
        data_req = 1'b0;
    endtask

    // Starve the driver for 5 requests, then resync. The flag must clear but
    // the counter must keep its value.
    task automatic test_underflow();
        data_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            if (pixel_data !== FILL_COLOR) begin $display("[TB] FAIL uf_pixel_%0d: got %h, expected %h", k, pixel_data, FILL_COLOR); testsFailed++; end
            testsRun++;
        end
        data_req = 1'b0;
        if (underflow !== 1'b1) begin $display("[TB] FAIL uf_flag: got %b, expected 1", underflow); testsFailed++; end
        testsRun++;
`ifdef LCD_FIFO_STATS_EN
        if (underflow_cnt !== 16'd5) begin $display("[TB] FAIL uf_cnt: got %0d, expected 5", underflow_cnt); testsFailed++; end
        testsRun++;
`endif
        out_vsync = 1'b1;
        step(2);
        out_vsync = 1'b0;
        if (underflow !== 1'b0) begin $display("[TB] FAIL uf_flag_cleared: got %b, expected 0", underflow); testsFailed++; end
        testsRun++;
        if (in_ready !== 1'b1) begin $display("[TB] FAIL uf_resync_ready: got %b, expected 1", in_ready); testsFailed++; end
        testsRun++;
        if (frame_active !== 1'b0) begin $display("[TB] FAIL uf_resync_inactive: got %b, expected 0", frame_active); testsFailed++; end
        testsRun++;
`ifdef LCD_FIFO_STATS_EN
        if (underflow_cnt !== 16'd5) begin $display("[TB] FAIL uf_cnt_kept: got %0d, expected 5", underflow_cnt); testsFailed++; end
        testsRun++;
`endif
    endtask

    // Flush a buffer holding 7 words, then hold vsync high for 100 more
    // cycles. A word pushed during the hold must survive.
    task automatic test_vsync_flush();
        applyStimulus(16'hD000, 1'b1);
        for (int i = 1; i < 7; i++) begin
            applyStimulus(16'hD000 + 16'(i), 1'b0);
        end
        if (fill_level !== 5'd7) begin $display("[TB] FAIL vs_pre_fill: got %0d, expected 7", fill_level); testsFailed++; end
        testsRun++;
        in_data   = 16'hEEEE;
        in_sof    = 1'b1;
        in_valid  = 1'b1;
        out_vsync = 1'b1;
        #1;
        if (in_ready !== 1'b0) begin $display("[TB] FAIL vs_edge_ready: got %b, expected 0", in_ready); testsFailed++; end
        testsRun++;
        step(1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (in_ready !== 1'b0) begin $display("[TB] FAIL vs_flush_ready: got %b, expected 0", in_ready); testsFailed++; end
        testsRun++;
        if (frame_active !== 1'b0) begin $display("[TB] FAIL vs_flush_inactive: got %b, expected 0", frame_active); testsFailed++; end
        testsRun++;
        step(1);
        if (fill_level !== 5'd0) begin $display("[TB] FAIL vs_flushed_fill: got %0d, expected 0", fill_level); testsFailed++; end
        testsRun++;
        if (in_ready !== 1'b1) begin $display("[TB] FAIL vs_sync_ready: got %b, expected 1", in_ready); testsFailed++; end
        testsRun++;
        step(50);
        applyStimulus(16'h7777, 1'b1);
        step(49);
        if (fill_level !== 5'd1) begin $display("[TB] FAIL vs_held_fill: got %0d, expected 1", fill_level); testsFailed++; end
        testsRun++;
        if (frame_active !== 1'b1) begin $display("[TB] FAIL vs_held_active: got %b, expected 1", frame_active); testsFailed++; end
        testsRun++;
        out_vsync = 1'b0;
        data_req  = 1'b1;
        step(1);
        data_req = 1'b0;
        if (pixel_data !== 16'h7777) begin $display("[TB] FAIL vs_held_data: got %h, expected 7777", pixel_data); testsFailed++; end
        testsRun++;
    endtask

    // Assert reset between clock edges while a frame is running. All outputs
    // must return to their reset values at once, and the FSM must be in IDLE.
    task automatic test_async_reset();
        data_req = 1'b1;
        step(1);
        data_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'h9000 + 16'(i), 1'b0);
        end
        if (fill_level !== 5'd5) begin $display("[TB] FAIL rst_pre_fill: got %0d, expected 5", fill_level); testsFailed++; end
        testsRun++;
        if (underflow !== 1'b1) begin $display("[TB] FAIL rst_pre_underflow: got %b, expected 1", underflow); testsFailed++; end
        testsRun++;
        #2;
        sys_rst_n = 1'b0;
        #1;
        if (pixel_data !== 16'h0000) begin $display("[TB] FAIL rst_async_pixel: got %h, expected 0000", pixel_data); testsFailed++; end
        testsRun++;
        if (fill_level !== 5'd0) begin $display("[TB] FAIL rst_async_fill: got %0d, expected 0", fill_level); testsFailed++; end
        testsRun++;
        if (underflow !== 1'b0) begin $display("[TB] FAIL rst_async_underflow: got %b, expected 0", underflow); testsFailed++; end
        testsRun++;
        if (frame_active !== 1'b0) begin $display("[TB] FAIL rst_async_active: got %b, expected 0", frame_active); testsFailed++; end
        testsRun++;
        if (in_ready !== 1'b0) begin $display("[TB] FAIL rst_async_ready: got %b, expected 0", in_ready); testsFailed++; end
        testsRun++;
`ifdef LCD_FIFO_STATS_EN
        if (underflow_cnt !== 16'd0) begin $display("[TB] FAIL rst_async_cnt: got %0d, expected 0", underflow_cnt); testsFailed++; end
        testsRun++;
`endif
        step(1);
        sys_rst_n = 1'b1;
        in_data   = 16'h4242;
        in_sof    = 1'b1;
        in_valid  = 1'b1;
        data_req  = 1'b1;
        #1;
        if (in_ready !== 1'b0) begin $display("[TB] FAIL idle_ready: got %b, expected 0", in_ready); testsFailed++; end
        testsRun++;
        step(1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        data_req = 1'b0;
        if (pixel_data !== FILL_COLOR) begin $display("[TB] FAIL idle_req_pixel: got %h, expected %h", pixel_data, FILL_COLOR); testsFailed++; end
        testsRun++;
        if (underflow !== 1'b0) begin $display("[TB] FAIL idle_req_underflow: got %b, expected 0", underflow); testsFailed++; end
        testsRun++;
        if (fill_level !== 5'd0) begin $display("[TB] FAIL idle_fill: got %0d, expected 0", fill_level); testsFailed++; end
        testsRun++;
`ifdef LCD_FIFO_STATS_EN
        if (underflow_cnt !== 16'd0) begin $display("[TB] FAIL idle_req_cnt: got %0d, expected 0", underflow_cnt); testsFailed++; end
        testsRun++;
`endif
        out_vsync = 1'b1;
        step(2);
        out_vsync = 1'b0;
        if (in_ready !== 1'b1) begin $display("[TB] FAIL idle_to_sync_ready: got %b, expected 1", in_ready); testsFailed++; end
        testsRun++;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        sys_rst_n   = 1'b0;
        in_data     = 16'h0000;
        in_sof      = 1'b0;
        in_valid    = 1'b0;
        out_vsync   = 1'b0;
        data_req    = 1'b0;

        test_reset();
        test_sync_and_read();
        test_full();
        test_back_to_back();
        test_underflow();
        test_vsync_flush();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/lcd_pixel_fifo.md
# lcd_pixel_fifo

Single-clock pixel elastic buffer that sits directly upstream of the RGB LCD driver. It accepts an RGB565 pixel stream with start-of-frame marking from a valid/ready source, such as a pattern generator or frame-buffer reader. It answers the driver's `data_req` with `pixel_data` exactly one `lcd_clk` later. It re-aligns to the source frame on every rising edge of the driver's `out_vsync` and substitutes a fill colour on underflow.

## Interface
Parameters:
- `DEPTH_LOG2`, 10: FIFO depth is 2^DEPTH_LOG2 words of 16 bits.
- `UNDERFLOW_COLOR`, 16'h0000: pixel driven when no data is available.

Ports:
- `lcd_clk` in 1: pixel clock; all logic on the rising edge.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in 16: RGB565 pixel from the source.
- `in_sof` in 1: qualifies `in_data` as pixel (0,0) of a frame.
- `in_valid` in 1: source word valid.
- `in_ready` out 1: word accepted when `in_valid && in_ready`; combinational.
- `out_vsync` in 1: frame restart from the driver; acts on its rising edge only.
- `data_req` in 1: driver requests one pixel.
- `pixel_data` out 16: pixel answering `data_req`, registered.
- `fill_level` out DEPTH_LOG2+1: words held, registered.
- `underflow` out 1: sticky; set on any starved request in the current frame.
- `frame_active` out 1: high in RUN.
- `underflow_cnt` out 16: only with `LCD_FIFO_STATS_EN` (see Configuration).

## Operation
- `vs_rise = out_vsync & ~vs_d`, where `vs_d` is `out_vsync` registered (reset 0).
- States are IDLE, FLUSH, SYNC and RUN. Reset enters IDLE.
- `vs_rise` in any state moves the FSM to FLUSH on the next cycle. It has priority over every other transition.
- IDLE:
  - `in_ready=0`.
  - Waits for `vs_rise`.
- FLUSH (one cycle):
  - Read and write pointers and `fill_level` are cleared to 0, and `underflow` is cleared.
  - `in_ready=0`.
  - Next state is SYNC.
- SYNC:
  - `in_ready=1`.
  - Accepted words with `in_sof=0` are discarded.
  - The first accepted word with `in_sof=1` is written; next state is RUN.
- RUN:
  - `in_ready = !full`; accepted words are written.
  - An `in_sof=1` word in RUN is written like any other word; it does not cause a resync.
- Read: `data_req && state==RUN && !empty` pops the head; `pixel_data` takes it next cycle.
- Starved request: `data_req && state==RUN && empty`.
  - `pixel_data` takes `UNDERFLOW_COLOR`.
  - `underflow` is set.
  - The counter increments (if compiled in).
- `data_req` outside RUN: `pixel_data` takes `UNDERFLOW_COLOR`; not counted, `underflow` unchanged.
- `data_req=0`: `pixel_data` holds its value.
- Simultaneous push and pop in one cycle: both happen and `fill_level` is unchanged.
- A push while full cannot occur because `in_ready=0`.
- Pointers are DEPTH_LOG2 bits and wrap modulo the depth. Full/empty are derived from `fill_level` (full = 2^DEPTH_LOG2, empty = 0).

## Timing
- Reset values:
  - `pixel_data`=16'h0000
  - `fill_level`=0
  - `underflow`=0
  - `frame_active`=0
  - `underflow_cnt`=0
  - `in_ready`=0 (IDLE)
  - all pointers 0
- Latency: `data_req` high in cycle N gives `pixel_data` valid in N+1. This matches the driver's registered data enable.
- Write-to-readable: a word pushed in cycle N can be popped by a `data_req` in N+1.
- `in_ready` is forced 0 in the `vs_rise` cycle; no word is accepted that cycle.
- Timing across a flush:
  - Cycle N: `vs_rise`.
  - Cycle N+1: FLUSH.
  - Cycle N+2: SYNC, with `in_ready=1` at the earliest.
- Mid-operation reset returns everything to reset values immediately, asynchronously.
- `fill_level` and `frame_active` update one cycle after the causing event.

## Configuration
- `LCD_FIFO_STATS_EN` defined:
  - Adds port `underflow_cnt`, a 16-bit counter of starved RUN requests.
  - It saturates at 16'hFFFF, is cleared only by reset, and is not cleared by FLUSH.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset, then pulse `out_vsync` for 101 cycles. Push 0x0001 (no sof), then 0x1234 (sof), then 0x5678. Then `data_req` for 2 cycles. Required response:
  - 0x0001 is dropped.
  - `pixel_data` reads 0x1234, then 0x5678, each one cycle after its request.
  - `frame_active`=1.
- In RUN with DEPTH_LOG2=4, push 16 words with `data_req`=0. Required response:
  - `fill_level`=16 and `in_ready`=0.
  - One `data_req` brings `fill_level` to 15 and `in_ready`=1.
- In RUN with `fill_level`=3, hold push and `data_req` together for 10 cycles. Required response: `fill_level` stays 3 and the data order is preserved.
- Empty FIFO in RUN, `data_req` for 5 cycles. Required response:
  - `pixel_data`=`UNDERFLOW_COLOR` each cycle.
  - `underflow`=1.
  - `underflow_cnt`=5 with the macro defined.
  - After the next `vs_rise`, `underflow`=0 while `underflow_cnt` is still 5.
- With `fill_level`=7, raise `out_vsync`. Required response:
  - `in_ready`=0 in the edge cycle.
  - `fill_level`=0 after FLUSH, state SYNC.
  - Holding `out_vsync` high for 100 more cycles triggers no further flush.
- Assert `sys_rst_n`=0 mid-frame with `fill_level`=5. Required response: all outputs reach their reset values within the same cycle, and the FSM is in IDLE.
